card_shoe: RTL and testbench
============================

Name: card_shoe

Overview:
- Sequential card source for the baccarat datapath: a 52-card shoe that shuffles under LFSR control and deals one card per handshake.
- Deals without replacement.
- Each dealt card uses the rank encoding the scoring logic consumes: 1=Ace, 2..10 pips, 11..13 J/Q/K.
- Sits between the controller, which requests shuffles and cards, and the hand registers/scoring path.

Parameters:
- SEED_DEFAULT, 16'hACE1: LFSR seed used when the seed input is 0 (an all-zero LFSR locks up).
- CUT_DEPTH, 6: remaining-card threshold for the cut-card flag (optional feature).

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- seed  in  16  shuffle seed, sampled on the cycle shuffle is accepted.
- shuffle  in  1  single-cycle request to restore all 52 cards and shuffle.
- busy  out  1  high while shuffling.
- card_valid  out  1  a card is offered.
- card_ready  in  1  consumer accepts the offered card.
- card  out  4  rank of the offered card; 0 when card_valid=0.
- remaining  out  6  undealt cards, 0..52.
- empty  out  1  remaining==0 and not busy.
- cut_reached  out  1  see Optional Feature.

Behaviour:
- Storage: deck[0..51], 4 bits each; top pointer (0..52); 16-bit LFSR; swap index i (0..51).
- Reset (async): deck[k]=(k mod 13)+1; top=0; state DEAL; LFSR=SEED_DEFAULT.
- Reset output values: busy=0, remaining=52, empty=0, card_valid=1, card=1, cut_reached=0.
- Reset mid-shuffle aborts the shuffle and restores the ordered deck.
- States:
  - DEAL: card_valid = (remaining!=0) && !shuffle. card = deck[top] when valid.
  - Transfer occurs when card_valid && card_ready: top+1, remaining-1 at the next edge.
  - card_valid is a combinational function of state, top and shuffle.
  - remaining==0: card_valid=0, empty=1. card_ready is ignored.
  - shuffle=1 in DEAL:
    - No transfer that cycle, even with card_ready=1.
    - LFSR loads seed, or SEED_DEFAULT if seed==0.
    - top=0, remaining=52, i=51, next state SHUF.
  - SHUF: busy=1, card_valid=0, empty=0; shuffle and card_ready are ignored. Each cycle:
    - j = lfsr[5:0], then the LFSR advances one step.
    - If j<=i: swap deck[i] and deck[j]; if i==1 go to DEAL, else i-1.
    - If j>i: reject and retry next cycle with no swap.
- Shuffle algorithm: Fisher-Yates with rejection sampling.
- LFSR: Galois, right shift, taps 16'hB400. Next = (l>>1) ^ (l[0] ? 16'hB400 : 0).
- Shuffle latency is data dependent (≥51 cycles) and fully deterministic for a given seed.
- Shuffle restores all 52 cards regardless of how many were dealt; cards already dealt are not excluded.
- Arithmetic: j compared to i as unsigned 6-bit; top/remaining never wrap (guarded at 52/0).

Optional Feature:
- Macro CARD_SHOE_CUT_CARD_EN.
- Defined: cut_reached = (state==DEAL) && (remaining<=CUT_DEPTH), combinational. Cleared by shuffle (low while busy) and by reset.
- Undefined: cut_reached tied 0 and the comparator is not built; all other behaviour is identical.

Decomposition:
- Package card_pkg:
  - typedef card_t (logic[3:0]).
  - DECK_SIZE=52, NUM_RANKS=13, LFSR_TAPS=16'hB400.
  - State enum shoe_state_t {DEAL, SHUF}.
  - RANK_ACE=1, RANK_KING=13.
- Sub-module shoe_lfsr:
  - Inputs: clock, reset, load, load_value[15:0], step.
  - Output: value[15:0].
  - Load has priority over step.
- Deck array, pointer logic and FSM live in card_shoe.

Test Plan:
- Ordered deal: reset, card_ready=1 → cards 1,2..13,1..13 ×4 over 52 cycles. Then remaining=0, empty=1, card_valid=0, card=0.
- Backpressure: after reset, card_ready=0 for 5 cycles → card=1, remaining=52 held. One ready cycle → card=2, remaining=51.
- Shuffle with seed=16'h1234:
  - busy=1 until done, then card_valid=1.
  - The 52 dealt cards contain each rank 1..13 exactly 4 times and match the golden model.
  - Repeating with the same seed gives an identical sequence.
  - seed=0 gives the same sequence as seed=16'hACE1.
- Priority: deal 10 cards, then shuffle=1 with card_ready=1 in the same cycle → no transfer, remaining=52, busy=1. A shuffle pulse while busy is ignored and the shuffle length is unchanged.
- Reset mid-shuffle (20 cycles into SHUF) → busy=0, ordered deck: first card 1, remaining=52.
- With CARD_SHOE_CUT_CARD_EN, ordered deal:
  - cut_reached=0 at remaining=7.
  - cut_reached=1 on the cycle remaining becomes 6; it stays 1 until empty.
  - cut_reached=0 after shuffle.
- Without the macro, cut_reached is always 0.

Source files
------------

// File: rtl/card_pkg.sv
// Shared types and constants for the 52-card shoe: rank encoding, deck size, LFSR taps.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t       RANK_ACE  = 4'd1;
  localparam card_t       RANK_KING = 4'd13;
  localparam int unsigned NUM_RANKS = int'(RANK_KING) - int'(RANK_ACE) + 1;
  localparam int unsigned DECK_SIZE = 52;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {DEAL, SHUF} shoe_state_t;

  // Rank held at deck position k in a freshly ordered shoe.
  function automatic card_t init_rank(input int unsigned k);
    return card_t'(int'(RANK_ACE) + int'(k % NUM_RANKS));
  endfunction

  // Galois, right-shifting step.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/card_shoe_if.sv
// Controller-facing bundle of the card shoe: shuffle request, card handshake and status.
interface card_shoe_if;
  import card_pkg::*;

  logic [15:0] seed;
  logic        shuffle;
  logic        busy;
  logic        card_valid;
  logic        card_ready;
  card_t       card;
  logic [5:0]  remaining;
  logic        empty;
  logic        cut_reached;

  modport master (
    output seed, shuffle, card_ready,
    input  busy, card_valid, card, remaining, empty, cut_reached
  );

  modport slave (
    input  seed, shuffle, card_ready,
    output busy, card_valid, card, remaining, empty, cut_reached
  );

endinterface

// File: rtl/shoe_lfsr.sv
// 16-bit Galois LFSR that drives shuffle index selection; load takes priority over step.
module shoe_lfsr
  import card_pkg::*;
#(
  parameter logic [15:0] ResetValue = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [15:0] load_value_i,
  input  logic        step_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = load_value_i;
    end else if (step_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= ResetValue;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: Fisher-Yates shuffle with rejection sampling, deals one card per handshake.
// Optional cut-card flag built only when CARD_SHOE_CUT_CARD_EN is defined.
module card_shoe
  import card_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1,
  parameter int unsigned CUT_DEPTH    = 6
) (
  input  logic        clk_i,
  input  logic        rst_i,
  card_shoe_if.slave  bus
);

  shoe_state_t state_q, state_d;
  card_t       deck_q [DECK_SIZE];
  card_t       deck_d [DECK_SIZE];
  logic [5:0]  top_q, top_d;
  logic [5:0]  idx_q, idx_d;

  logic [15:0] lfsr_value;
  logic [15:0] lfsr_load_value;
  logic        lfsr_load;
  logic        lfsr_step;
  logic [5:0]  pick;
  logic        at_end;
  logic        card_valid;
  logic        busy;
  logic [5:0]  remaining;

  shoe_lfsr #(
    .ResetValue (SEED_DEFAULT)
  ) u_lfsr (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .load_i       (lfsr_load),
    .load_value_i (lfsr_load_value),
    .step_i       (lfsr_step),
    .value_o      (lfsr_value)
  );

  assign pick            = lfsr_value[5:0];
  assign at_end          = (top_q == 6'(DECK_SIZE));
  assign remaining       = 6'(DECK_SIZE) - top_q;
  // An all-zero seed would lock the LFSR, so fall back to the default.
  assign lfsr_load_value = (bus.seed == 16'h0000) ? SEED_DEFAULT : bus.seed;

  always_comb begin
    state_d    = state_q;
    top_d      = top_q;
    idx_d      = idx_q;
    deck_d     = deck_q;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    card_valid = 1'b0;
    busy       = 1'b0;
    unique case (state_q)
      DEAL: begin
        card_valid = !at_end && !bus.shuffle;
        if (bus.shuffle) begin
          lfsr_load = 1'b1;
          top_d     = '0;
          idx_d     = 6'(DECK_SIZE - 1);
          state_d   = SHUF;
        end else if (card_valid && bus.card_ready) begin
          top_d = top_q + 6'd1;
        end
      end
      SHUF: begin
        busy      = 1'b1;
        lfsr_step = 1'b1;
        // Picks beyond the current index are rejected so every slot stays equally likely.
        if (pick <= idx_q) begin
          deck_d[idx_q] = deck_q[pick];
          deck_d[pick]  = deck_q[idx_q];
          if (idx_q == 6'd1) begin
            state_d = DEAL;
          end else begin
            idx_d = idx_q - 6'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= DEAL;
      top_q   <= '0;
      idx_q   <= 6'(DECK_SIZE - 1);
      for (int k = 0; k < DECK_SIZE; k++) begin
        deck_q[k] <= init_rank(k);
      end
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      idx_q   <= idx_d;
      deck_q  <= deck_d;
    end
  end

  assign bus.busy       = busy;
  assign bus.card_valid = card_valid;
  assign bus.card       = card_valid ? deck_q[top_q] : '0;
  assign bus.remaining  = remaining;
  assign bus.empty      = (remaining == 6'd0) && !busy;

`ifdef CARD_SHOE_CUT_CARD_EN
  assign bus.cut_reached = (state_q == DEAL) && (remaining <= 6'(CUT_DEPTH));
`else
  logic unused_cut_depth;
  assign unused_cut_depth = ^CUT_DEPTH;
  assign bus.cut_reached  = 1'b0;
`endif

  logic unused_lfsr_hi;
  assign unused_lfsr_hi = ^lfsr_value[15:6];

endmodule

// File: tb/tb_card_shoe.sv
// Scoreboard bench for card_shoe: stimulus queues expected cards, a monitor checks each handshake.
// Cut-card expectations follow CARD_SHOE_CUT_CARD_EN.
module tb_card_shoe;
  import card_pkg::*;

`ifdef CARD_SHOE_CUT_CARD_EN
  localparam bit CutEn = 1'b1;
`else
  localparam bit CutEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  card_shoe_if bus();

  card_shoe #(
    .SEED_DEFAULT (16'hACE1),
    .CUT_DEPTH    (6)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  int dealt_q[$];
  int m_deck[52];
  int m_top;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted card is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.card_valid && bus.card_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_card", int'(bus.card), -1);
      end else begin
        chk("card", int'(bus.card), exp_q.pop_front());
        dealt_q.push_back(int'(bus.card));
      end
    end
  end

  function automatic logic [15:0] m_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 52; k++) m_deck[k] = (k % 13) + 1;
    m_top = 0;
  endtask

  task automatic m_shuffle(input logic [15:0] s, output int cycles);
    logic [15:0] l;
    int i, j, t;
    l = (s == 16'h0000) ? 16'hACE1 : s;
    i = 51;
    cycles = 0;
    m_top = 0;
    while (i >= 1 && cycles < 5000) begin
      cycles++;
      j = int'(l[5:0]);
      l = m_step(l);
      if (j <= i) begin
        t = m_deck[i];
        m_deck[i] = m_deck[j];
        m_deck[j] = t;
        i--;
      end
    end
  endtask

  task automatic do_reset();
    bus.shuffle    = 1'b0;
    bus.card_ready = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    m_reset();
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_status(input string tag);
    int rem;
    rem = 52 - m_top;
    @(negedge clk);
    chk({tag, ".remaining"}, int'(bus.remaining), rem);
    chk({tag, ".empty"}, int'(bus.empty), int'(rem == 0));
    chk({tag, ".busy"}, int'(bus.busy), 0);
    chk({tag, ".card_valid"}, int'(bus.card_valid), int'(rem != 0));
    chk({tag, ".card"}, int'(bus.card), (rem != 0) ? m_deck[m_top] : 0);
    chk({tag, ".cut_reached"}, int'(bus.cut_reached), int'(CutEn && rem <= 6));
    @(posedge clk); #1;
  endtask

  task automatic deal(input int n);
    int got, guard;
    for (int k = 0; k < n; k++) exp_q.push_back(m_deck[m_top + k]);
    m_top += n;
    got = 0;
    guard = 0;
    bus.card_ready = 1'b1;
    while (got < n && guard < n + 20) begin
      @(negedge clk);
      if (bus.card_valid) got++;
      guard++;
      @(posedge clk); #1;
      if (got == n) bus.card_ready = 1'b0;
    end
    bus.card_ready = 1'b0;
    chk("deal_count", got, n);
  endtask

  task automatic do_shuffle(input logic [15:0] s, input bit with_ready, input bit pulse_again);
    int exp_len, n;
    bus.seed       = s;
    bus.shuffle    = 1'b1;
    bus.card_ready = with_ready;
    @(negedge clk);
    chk("shuf_req.card_valid", int'(bus.card_valid), 0);
    chk("shuf_req.card", int'(bus.card), 0);
    @(posedge clk); #1;
    bus.shuffle    = 1'b0;
    bus.card_ready = 1'b0;
    m_shuffle(s, exp_len);
    @(negedge clk);
    chk("shuf.busy", int'(bus.busy), 1);
    chk("shuf.remaining", int'(bus.remaining), 52);
    chk("shuf.empty", int'(bus.empty), 0);
    chk("shuf.cut_reached", int'(bus.cut_reached), 0);
    n = 0;
    while (bus.busy && n < 3000) begin
      n++;
      @(posedge clk); #1;
      bus.shuffle = pulse_again && (n == 5);
      @(negedge clk);
    end
    bus.shuffle = 1'b0;
    chk("shuf.length", n, exp_len);
    @(posedge clk); #1;
  endtask

  task automatic check_rank_counts(input string tag);
    int cnt;
    for (int r = 1; r <= 13; r++) begin
      cnt = 0;
      foreach (dealt_q[k]) if (dealt_q[k] == r) cnt++;
      chk({tag, ".rank_count"}, cnt, 4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.seed       = 16'h0000;
    bus.shuffle    = 1'b0;
    bus.card_ready = 1'b0;
    rst = 1'b1;
    m_reset();
    #3;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state, then backpressure.
    check_status("reset");
    repeat (5) check_status("hold");
    deal(1);
    check_status("after_one");

    // Ordered deal to empty, with the cut-card boundary.
    do_reset();
    deal(45);
    check_status("rem7");
    deal(1);
    check_status("rem6");
    deal(6);
    check_status("empty");
    bus.card_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.card_ready = 1'b0;
    check_status("empty_ready");

    // Seeded shuffle, repeat with the same seed, and zero seed.
    do_reset();
    do_shuffle(16'h1234, 1'b0, 1'b0);
    check_status("shuf1");
    dealt_q.delete();
    deal(52);
    check_rank_counts("shuf1");
    check_status("shuf1_empty");

    do_reset();
    do_shuffle(16'h1234, 1'b0, 1'b0);
    deal(52);

    do_reset();
    do_shuffle(16'h0000, 1'b0, 1'b0);
    dealt_q.delete();
    deal(52);
    check_rank_counts("seed0");

    // Shuffle wins over a simultaneous handshake; pulse while busy is ignored.
    do_reset();
    deal(10);
    do_shuffle(16'h5A5A, 1'b1, 1'b1);
    check_status("prio");
    deal(52);

    // Reset in the middle of a shuffle.
    do_reset();
    bus.seed    = 16'h1234;
    bus.shuffle = 1'b1;
    @(posedge clk); #1;
    bus.shuffle = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid.busy_before", int'(bus.busy), 1);
    do_reset();
    check_status("mid_reset");
    deal(3);
    check_status("mid_deal");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
